// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared state encoding and widths for the PLL reset sequencer
package pll_ctrl_pkg;
    localparam int RETRY_W = 2;
    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        READY     = 3'd3,
        FAIL      = 3'd4
    } state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    // shift the async level through two flops to settle metastability
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: sequences PLL reset, qualifies lock with retry, drives system reset
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYC = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 256,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               locked,
    input  logic               restart,
    output logic               pll_reset,
    output logic               pll_ready,
    output logic               sys_rst_n,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state_dbg
);
    state_t           state;
    logic             locked_s;
    logic [CNT_W-1:0] hold_cnt, to_cnt, stb_cnt;

    sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(locked), .q(locked_s));

    assign state_dbg = state;

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // sequencer: restart overrides everything; timeout beats lock events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HOLD;
            pll_reset <= 1'b1;
            pll_ready <= 1'b0;
            sys_rst_n <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= '0;
            hold_cnt  <= '0;
            to_cnt    <= '0;
            stb_cnt   <= '0;
        end else if (restart) begin
            state     <= HOLD;
            pll_reset <= 1'b1;
            pll_ready <= 1'b0;
            sys_rst_n <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= '0;
            hold_cnt  <= '0;
            to_cnt    <= '0;
            stb_cnt   <= '0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt >= CNT_W'(RST_HOLD_CYC - 1)) begin
                        state     <= WAIT_LOCK;
                        pll_reset <= 1'b0;
                        hold_cnt  <= '0;
                        to_cnt    <= '0;
                    end else begin
                        hold_cnt <= inc(hold_cnt);
                    end
                end
                WAIT_LOCK, STABLE: begin
                    if (to_cnt >= CNT_W'(LOCK_TIMEOUT - 1)) begin
                        if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
                            state <= FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state     <= HOLD;
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                        end
                        pll_reset <= 1'b1;
                        hold_cnt  <= '0;
                        to_cnt    <= '0;
                        stb_cnt   <= '0;
                    end else if (!locked_s) begin
                        state   <= WAIT_LOCK;
                        stb_cnt <= '0;
                        to_cnt  <= inc(to_cnt);
                    end else if (state == STABLE && stb_cnt >= CNT_W'(LOCK_STABLE - 1)) begin
                        state     <= READY;
                        pll_ready <= 1'b1;
                        sys_rst_n <= 1'b1;
                        retry_cnt <= '0;
                    end else begin
                        state   <= STABLE;
                        stb_cnt <= (state == STABLE) ? inc(stb_cnt) : '0;
                        to_cnt  <= inc(to_cnt);
                    end
                end
                READY: begin
                    if (!locked_s) begin
                        state     <= HOLD;
                        pll_reset <= 1'b1;
                        pll_ready <= 1'b0;
                        sys_rst_n <= 1'b0;
                        hold_cnt  <= '0;
                    end
                end
                FAIL: begin
                    pll_reset <= 1'b1;
                    fail      <= 1'b1;
                    pll_ready <= 1'b0;
                    sys_rst_n <= 1'b0;
                end
                default: begin
                    state     <= HOLD;
                    pll_reset <= 1'b1;
                    pll_ready <= 1'b0;
                    sys_rst_n <= 1'b0;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: directed vector table plus hand sequences for the PLL sequencer
module tb_pll_reset_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, locked, restart;
    logic       pll_reset, pll_ready, sys_rst_n, fail;
    logic [1:0] retry_cnt;
    logic [2:0] state_dbg;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        int         n;
        logic       lk;
        logic       rs;
        logic [8:0] exp;
    } vec_t;
    vec_t vq[$];

    pll_reset_ctrl #(
        .RST_HOLD_CYC(4), .LOCK_TIMEOUT(32), .LOCK_STABLE(8), .MAX_RETRY(2), .CNT_W(17)
    ) dut (
        .clk(clk), .rst_n(rst_n), .locked(locked), .restart(restart),
        .pll_reset(pll_reset), .pll_ready(pll_ready), .sys_rst_n(sys_rst_n),
        .fail(fail), .retry_cnt(retry_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {state_dbg, pll_reset, pll_ready, sys_rst_n, fail, retry_cnt};
    endfunction

    function automatic logic [8:0] pk(input logic [2:0] st, input logic pr, rdy, srn, f,
                                      input logic [1:0] rc);
        return {st, pr, rdy, srn, f, rc};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input int n, input logic lk, rs, input logic [2:0] st,
                       input logic pr, rdy, srn, f, input logic [1:0] rc);
        vec_t v;
        v.n = n; v.lk = lk; v.rs = rs; v.exp = pk(st, pr, rdy, srn, f, rc);
        vq.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; locked = 1'b0; restart = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("reset_vals", outs(), pk(0, 1, 0, 0, 0, 0));
        rst_n = 1'b1;
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (pll_reset == lvl && n < 200);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!pll_ready && n < 60);
    endtask

    initial begin
        int n, k, bad;
        logic saw_stb, saw_rdy;
        // nominal lock, loss of lock in READY, restart from READY, restart held
        add(3, 0, 0, 0, 1, 0, 0, 0, 0);
        add(5, 0, 0, 1, 0, 0, 0, 0, 0);
        add(2, 1, 0, 1, 0, 0, 0, 0, 0);
        add(8, 1, 0, 2, 0, 0, 0, 0, 0);
        add(4, 1, 0, 3, 0, 1, 1, 0, 0);
        add(2, 0, 0, 3, 0, 1, 1, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(3, 1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0, 0, 0);
        add(8, 1, 0, 2, 0, 0, 0, 0, 0);
        add(2, 1, 0, 3, 0, 1, 1, 0, 0);
        add(1, 1, 1, 0, 1, 0, 0, 0, 0);
        add(3, 1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0, 0, 0);
        add(8, 1, 0, 2, 0, 0, 0, 0, 0);
        add(1, 1, 0, 3, 0, 1, 1, 0, 0);
        add(3, 1, 1, 0, 1, 0, 0, 0, 0);
        add(3, 1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0, 0, 0);

        do_reset();
        foreach (vq[i]) begin
            for (int c = 0; c < vq[i].n; c++) begin
                @(negedge clk);
                locked = vq[i].lk; restart = vq[i].rs;
                @(posedge clk); #1;
                chk($sformatf("vec%0d.%0d", i, c), outs(), vq[i].exp);
            end
        end
        @(negedge clk); restart = 1'b0;

        // async reset in the middle of STABLE
        do_reset();
        locked = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (state_dbg != 3'd2 && n < 50);
        chk("reach_stable", state_dbg, 3'd2);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_outs", outs(), pk(0, 1, 0, 0, 0, 0));
        #2 rst_n = 1'b1;
        run_len(1'b1, n);
        chk("rst6_hold_len", n, 4);
        wait_ready(n);
        chk("rst6_lock_lat", n, 9);
        chk("rst6_ready_outs", outs(), pk(3, 0, 1, 1, 0, 0));

        // lock flicker inside STABLE never completes and times out
        do_reset();
        run_len(1'b1, n);
        chk("flk_hold_len", n, 4);
        n = 0; k = 1; saw_stb = 1'b0; saw_rdy = 1'b0;
        do begin
            @(negedge clk); locked = ((k % 6) != 5); k++;
            @(posedge clk); #1; n++;
            if (state_dbg == 3'd2) saw_stb = 1'b1;
            if (pll_ready) saw_rdy = 1'b1;
        end while (state_dbg != 3'd0 && n < 80);
        chk("flk_timeout_len", n, 32);
        chk("flk_saw_stable", saw_stb, 1);
        chk("flk_no_ready", saw_rdy, 0);
        chk("flk_retry", retry_cnt, 1);

        // never locks: three attempts then sticky failure
        do_reset();
        for (int r = 0; r < 3; r++) begin
            run_len(1'b1, n);
            chk($sformatf("nl_hold_len%0d", r), n, 4);
            chk($sformatf("nl_retry%0d", r), retry_cnt, r);
            run_len(1'b0, n);
            chk($sformatf("nl_wait_len%0d", r), n, 32);
        end
        chk("nl_fail_outs", outs(), pk(4, 1, 0, 0, 1, 2));
        bad = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (outs() !== pk(4, 1, 0, 0, 1, 2)) bad++;
        end
        chk("nl_fail_sticky", bad, 0);

        // restart out of FAIL, then a clean nominal sequence
        @(negedge clk); restart = 1'b1; locked = 1'b1;
        @(posedge clk); #1;
        chk("rs_fail_outs", outs(), pk(0, 1, 0, 0, 0, 0));
        @(negedge clk); restart = 1'b0;
        wait_ready(n);
        chk("rs_lock_lat", n, 13);
        chk("rs_ready_outs", outs(), pk(3, 0, 1, 1, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pll_reset_ctrl.md
Name: pll_reset_ctrl

Overview:
- Sequences the clock-generation PLL: drives its reset, waits for and qualifies `locked`, retries on timeout, and flags permanent failure.
- Generates the downstream system reset (`sys_rst_n`), released only once the PLL clocks are stable.
- Sits beside the PLL wrapper at the chip top and runs on the buffered board input clock (pre-PLL), never on a PLL output.

Parameters:
- RST_HOLD_CYC, 16: cycles `pll_reset` is held high per attempt (≥2).
- LOCK_TIMEOUT, 65536: cycles allowed from PLL reset release to qualified lock, per attempt.
- LOCK_STABLE, 256: consecutive cycles synchronized `locked` must stay high before READY.
- MAX_RETRY, 3: re-attempts after a timeout before FAIL.
- CNT_W, 17: width of the cycle counters; must hold max(RST_HOLD_CYC, LOCK_TIMEOUT, LOCK_STABLE).

Ports:
- clk, input, 1: free-running board reference clock, after input buffer.
- rst_n, input, 1: asynchronous, active-low block reset.
- locked, input, 1: PLL lock flag, asynchronous to clk; 2-flop synchronized internally (`locked_s`).
- restart, input, 1: synchronous single-cycle request to re-sequence the PLL.
- pll_reset, output, 1: active-high PLL reset, registered (glitch-free).
- pll_ready, output, 1: PLL output clocks valid.
- sys_rst_n, output, 1: active-low downstream reset; asserts asynchronously with rst_n, otherwise registered.
- fail, output, 1: retries exhausted, sticky.
- retry_cnt, output, 2: timeouts taken in the current sequence.
- state_dbg, output, 3: current state encoding, for debug.

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is asynchronous, active-low. All flops reset asynchronously; all outputs are registered.
- Reset values: state=HOLD, pll_reset=1, pll_ready=0, sys_rst_n=0, fail=0, retry_cnt=0, counters=0, sync flops=0.
- States: HOLD, WAIT_LOCK, STABLE, READY, FAIL.
- HOLD:
  - pll_reset=1; count cycles.
  - After RST_HOLD_CYC cycles in HOLD → WAIT_LOCK. The pll_reset falling edge coincides with entry to WAIT_LOCK.
- WAIT_LOCK:
  - pll_reset=0. Timeout counter starts at 0 on entry.
  - locked_s=1 → STABLE; stable counter cleared.
  - Timeout counter reaches LOCK_TIMEOUT-1 → timeout.
- STABLE:
  - Timeout counter keeps running; it is not cleared by lock flicker.
  - Stable counter increments while locked_s=1.
  - locked_s=0 → WAIT_LOCK, stable counter cleared, timeout counter preserved.
  - Stable counter reaches LOCK_STABLE-1 with locked_s=1 → READY.
  - Timeout in STABLE is handled as in WAIT_LOCK.
- Timeout, from WAIT_LOCK or STABLE:
  - retry_cnt==MAX_RETRY → FAIL.
  - Otherwise retry_cnt+1 and → HOLD.
- READY:
  - pll_ready=1, sys_rst_n=1, both set on the entry edge. retry_cnt cleared on entry.
  - locked_s=0 (loss of lock) → HOLD. pll_ready=0, sys_rst_n=0 and pll_reset=1 on that same edge.
  - Total lag from `locked` falling to sys_rst_n low: ≤3 clk cycles.
- FAIL:
  - pll_reset=1, fail=1, pll_ready=0, sys_rst_n=0.
  - Remains until restart or rst_n.
- restart:
  - Highest priority, valid in any state → HOLD with retry_cnt=0, fail=0, counters cleared.
  - Outputs take HOLD values on the next edge.
  - restart held high keeps the block in HOLD (hold counter kept at 0).
- Simultaneous events:
  - restart beats timeout and lock events.
  - In STABLE, timeout beats completion when both occur in the same cycle.
- Counters saturate; they never wrap.
- retry_cnt width is fixed at 2, so MAX_RETRY ≤ 3.
- rst_n assertion mid-sequence: immediate async return to the reset values.
- Unknown state encoding → HOLD.

Decomposition:
- Package `pll_ctrl_pkg`: state encoding constants (HOLD=0, WAIT_LOCK=1, STABLE=2, READY=3, FAIL=4) and the RETRY_W=2 constant.
- Sub-module `sync_2ff`: 2-flop synchronizer with async active-low reset to 0, used for `locked`.
- FSM and counters stay in `pll_reset_ctrl`.

Test Plan:
Bench parameters: RST_HOLD_CYC=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, MAX_RETRY=2.
1. Nominal lock: release rst_n; raise locked 5 cycles after pll_reset falls.
   - pll_reset high for exactly 4 cycles.
   - pll_ready and sys_rst_n rise 2 (sync) + 1 + 8 cycles after locked rises.
   - retry_cnt=0, fail=0.
2. Never locks: locked=0 forever.
   - Three HOLD pulses of 4 cycles, spaced by 32-cycle waits; retry_cnt steps 0→1→2.
   - Then fail=1, pll_reset=1, state_dbg=4, all stable for 200 cycles.
3. Lock flicker: in STABLE, drop locked for 1 cycle every 6 cycles.
   - READY never reached; timeout at 32 cycles from WAIT_LOCK entry; retry_cnt=1.
4. Loss of lock in READY: drop locked.
   - Within 3 cycles: sys_rst_n=0, pll_ready=0, pll_reset=1.
   - Re-lock → READY again, retry_cnt=0.
5. Restart from FAIL and from READY: 1-cycle restart pulse.
   - Next edge: state HOLD, fail=0, retry_cnt=0, pll_reset=1.
   - Nominal sequence then completes.
6. Async reset mid-STABLE: pulse rst_n low for 3 ns, off clock edge.
   - Outputs at reset values immediately (sys_rst_n=0 without a clk edge).
   - Sequence restarts cleanly.
